ddr3_cmd_tracker: RTL and testbench
===================================

DDR3_CMD_TRACKER -- requirements
Module: ddr3_cmd_tracker

Interface
REQ-001 SHALL have parameter BA_BITS, default 3, bank address width; NB = 2**BA_BITS banks.
REQ-002 SHALL have parameter ADDR_BITS, default 16, row/address width.
REQ-003 SHALL have parameter TRCD, default 11, minimum ACT-to-RD/WR spacing in ck cycles.
REQ-004 SHALL have parameter TRP, default 11, minimum PRE-to-ACT spacing in ck cycles.
REQ-005 SHALL have ports:
- ck  in  1  sole clock, rising edge; one clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- cke, cs_n, ras_n, cas_n, we_n  in  1 each  DDR3 command pins.
- ba  in  BA_BITS  bank address.
- addr  in  ADDR_BITS  row/column address; A10 = AP/all-banks, A12 = BC.
- cmd_code  out  5  registered decoded command.
- cmd_ba  out  BA_BITS  registered ba.
- cmd_row  out  ADDR_BITS  registered addr.
- cmd_col  out  11  registered {A11, A9:A0}.
- bank_open  out  NB  one bit per bank; 1 = row open.
- pwr_state  out  2  0 ACTIVE, 1 POWER_DOWN, 2 SELF_REFRESH.
- proto_err  out  1  one-cycle pulse, protocol violation.
- timing_err  out  1  one-cycle pulse, tRCD/tRP violation.
- err_count  out  16  saturating count of commands with any error.

Function
REQ-006 SHALL register cke as prev_cke every ck; the decode key is {prev_cke, cke, cs_n, ras_n, cas_n, we_n, A12, A10}.
REQ-007 SHALL use codes: NOP 0, DES 1, MRS 2, REF 3, SRE 4, SRX 5, PRE 6, PREA 7, ACT 8, WR 9, WRAP 10, RD 11, RDAP 12, PDE 13, PDX 14, ZQCL 15, ZQCS 16, UNK 31.
REQ-008 SHALL decode with prev_cke=cke=1 per JEDEC truth table: cs_n=1 DES; 0000 MRS; 0001 REF; 0010 PRE/PREA (A10); 0011 ACT; 0100 WR/WRAP (A10); 0101 RD/RDAP (A10); 0110 ZQCS/ZQCL (A10=0/1); 0111 NOP.
REQ-009 SHALL decode prev_cke=1, cke=0: REF-encoding -> SRE; NOP- or DES-encoding -> PDE; otherwise UNK.
REQ-010 SHALL decode prev_cke=0, cke=1 with NOP or DES encoding as SRX when pwr_state=SELF_REFRESH, else PDX; other encodings UNK.
REQ-011 SHALL report prev_cke=cke=0 as NOP with no error.
REQ-012 SHALL present cmd_code, cmd_ba, cmd_row, cmd_col, bank_open, pwr_state, proto_err, timing_err one ck after the sampled edge (latency 1).
REQ-013 SHALL update pwr_state: ACTIVE->SELF_REFRESH on SRE, ACTIVE->POWER_DOWN on PDE, SELF_REFRESH/POWER_DOWN->ACTIVE on SRX/PDX; no other transitions.
REQ-014 SHALL set bank_open[ba] and latch its row on ACT; clear bank_open[ba] on PRE, RDAP, WRAP; clear all on PREA.
REQ-015 SHALL pulse proto_err for: UNK; ACT to an open bank (row still relatched); RD/RDAP/WR/WRAP to a closed bank; MRS/REF/ZQCL/ZQCS/SRE with any bank open; any non-NOP/DES/exit command while pwr_state is not ACTIVE.
REQ-016 SHALL treat PRE to a closed bank and PREA with no banks open as legal.
REQ-017 SHALL increment err_count by exactly 1 per command flagged with proto_err, timing_err or both; saturate at 16'hFFFF.

Reset
REQ-018 SHALL, on rst_n low, asynchronously force cmd_code=NOP, cmd_ba=0, cmd_row=0, cmd_col=0, bank_open=0, pwr_state=ACTIVE, proto_err=0, timing_err=0, err_count=0, prev_cke=1, all timing counters=0.
REQ-019 SHALL, after reset mid-sequence, treat all banks as closed; the next RD without ACT is a proto_err.

Configuration
REQ-020 SHALL, with macro DDR3_CMD_TRACKER_TIMING_CHECK_EN defined, keep per-bank counters: ACT loads tRCD counter with TRCD-1; PRE/RDAP/WRAP load tRP counter with TRP-1 (PREA loads all); each decrements per ck, saturating at 0; RD/WR while tRCD counter nonzero, or ACT while tRP counter nonzero, pulses timing_err.
REQ-021 SHALL, without the macro, omit the counters and tie timing_err to 0.

Verification
REQ-022 Reset, ACT ba=2 row=0x1234, RD ba=2 after 12 cycles -> cmd_code 8 then 11, bank_open=8'h04, no errors.
REQ-023 RD ba=5 with bank 5 closed -> proto_err pulse one cycle later, err_count=1, cmd_code=11.
REQ-024 With macro: ACT ba=0, RD ba=0 3 cycles later -> timing_err=1, proto_err=0, err_count=1; without macro -> no error.
REQ-025 SRE (cke 1->0, REF encoding), hold cke=0 for 5 cycles, cke->1 with NOP -> codes 4, NOP x5, 5; pwr_state 2 then 0; PDE/PDX same flow yields 13, 14 and pwr_state 1.
REQ-026 Open banks 1 and 3, REF -> proto_err; PREA -> bank_open=0; force 65536 UNK commands -> err_count holds 16'hFFFF.

Source files
------------

// File: rtl/ddr3_cmd_tracker.sv
// DDR3 command decoder/tracker: registers the decoded command, tracks open banks and power state, flags errors.
// Optional per-bank tRCD/tRP checking is built only when DDR3_CMD_TRACKER_TIMING_CHECK_EN is defined.
module ddr3_cmd_tracker #(
  parameter int BA_BITS   = 3,
  parameter int ADDR_BITS = 16,
  parameter int TRCD      = 11,
  parameter int TRP       = 11
) (
  input  logic                    ck,
  input  logic                    rst_n,
  input  logic                    cke,
  input  logic                    cs_n,
  input  logic                    ras_n,
  input  logic                    cas_n,
  input  logic                    we_n,
  input  logic [BA_BITS-1:0]      ba,
  input  logic [ADDR_BITS-1:0]    addr,
  output logic [4:0]              cmd_code,
  output logic [BA_BITS-1:0]      cmd_ba,
  output logic [ADDR_BITS-1:0]    cmd_row,
  output logic [10:0]             cmd_col,
  output logic [2**BA_BITS-1:0]   bank_open,
  output logic [1:0]              pwr_state,
  output logic                    proto_err,
  output logic                    timing_err,
  output logic [15:0]             err_count
);
  localparam int NB = 2**BA_BITS;

  typedef enum logic [4:0] {
    C_NOP = 5'd0, C_DES = 5'd1, C_MRS = 5'd2, C_REF = 5'd3, C_SRE = 5'd4, C_SRX = 5'd5,
    C_PRE = 5'd6, C_PREA = 5'd7, C_ACT = 5'd8, C_WR = 5'd9, C_WRAP = 5'd10, C_RD = 5'd11,
    C_RDAP = 5'd12, C_PDE = 5'd13, C_PDX = 5'd14, C_ZQCL = 5'd15, C_ZQCS = 5'd16, C_UNK = 5'd31
  } cmd_e;

  typedef enum logic [1:0] {PWR_ACTIVE = 2'd0, PWR_DOWN = 2'd1, PWR_SREF = 2'd2} pwr_e;

  if (TRCD < 1 || TRP < 1 || ADDR_BITS < 13) begin : g_param_check
    $error("ddr3_cmd_tracker: TRCD/TRP must be >= 1 and ADDR_BITS >= 13");
  end

  logic            prev_cke;
  pwr_e            pwr_q, pwr_d;
  cmd_e            code;
  logic [2:0]      op;
  logic            proto, timing;
  logic [NB-1:0]   bank_d;
  logic [ADDR_BITS-1:0] open_row_unused [NB];

  assign op        = {ras_n, cas_n, we_n};
  assign pwr_state = pwr_q;

  always_comb begin
    code = C_UNK;
    case ({prev_cke, cke})
      2'b11: begin
        if (cs_n) code = C_DES;
        else begin
          case (op)
            3'b000:  code = C_MRS;
            3'b001:  code = C_REF;
            3'b010:  code = addr[10] ? C_PREA : C_PRE;
            3'b011:  code = C_ACT;
            3'b100:  code = addr[10] ? C_WRAP : C_WR;
            3'b101:  code = addr[10] ? C_RDAP : C_RD;
            3'b110:  code = addr[10] ? C_ZQCL : C_ZQCS;
            default: code = C_NOP;
          endcase
        end
      end
      2'b10: begin
        if (!cs_n && op == 3'b001)     code = C_SRE;
        else if (cs_n || op == 3'b111) code = C_PDE;
        else                           code = C_UNK;
      end
      2'b01: begin
        if (cs_n || op == 3'b111) code = (pwr_q == PWR_SREF) ? C_SRX : C_PDX;
        else                      code = C_UNK;
      end
      default: code = C_NOP;
    endcase
  end

  // Protocol legality against the bank table and power state seen before this command
  always_comb begin
    proto = 1'b0;
    case (code)
      C_UNK:                          proto = 1'b1;
      C_ACT:                          proto = bank_open[ba];
      C_RD, C_RDAP, C_WR, C_WRAP:     proto = ~bank_open[ba];
      C_MRS, C_REF, C_ZQCL, C_ZQCS, C_SRE: proto = |bank_open;
      default: ;
    endcase
    if (pwr_q != PWR_ACTIVE && !(code inside {C_NOP, C_DES, C_SRX, C_PDX}))
      proto = 1'b1;
  end

  always_comb begin
    bank_d = bank_open;
    case (code)
      C_ACT:                bank_d[ba] = 1'b1;
      C_PRE, C_RDAP, C_WRAP: bank_d[ba] = 1'b0;
      C_PREA:               bank_d     = '0;
      default: ;
    endcase
  end

  always_comb begin
    pwr_d = pwr_q;
    case (pwr_q)
      PWR_ACTIVE: begin
        if (code == C_SRE)      pwr_d = PWR_SREF;
        else if (code == C_PDE) pwr_d = PWR_DOWN;
      end
      PWR_DOWN, PWR_SREF: if (code == C_SRX || code == C_PDX) pwr_d = PWR_ACTIVE;
      default: pwr_d = PWR_ACTIVE;
    endcase
  end

`ifdef DDR3_CMD_TRACKER_TIMING_CHECK_EN
  localparam int TMAX  = (TRCD > TRP) ? TRCD : TRP;
  localparam int CNT_W = $clog2(TMAX + 1);

  logic [CNT_W-1:0] trcd_cnt [NB];
  logic [CNT_W-1:0] trp_cnt  [NB];

  always_comb begin
    timing = 1'b0;
    case (code)
      C_RD, C_RDAP, C_WR, C_WRAP: timing = (trcd_cnt[ba] != '0);
      C_ACT:                      timing = (trp_cnt[ba] != '0);
      default: ;
    endcase
  end

  // A counter reaching zero means the command may legally issue on that edge
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) begin
        trcd_cnt[b] <= '0;
        trp_cnt[b]  <= '0;
      end
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (code == C_ACT && ba == BA_BITS'(b))
          trcd_cnt[b] <= CNT_W'(TRCD - 1);
        else if (trcd_cnt[b] != '0)
          trcd_cnt[b] <= trcd_cnt[b] - CNT_W'(1);
        if (code == C_PREA || ((code inside {C_PRE, C_RDAP, C_WRAP}) && ba == BA_BITS'(b)))
          trp_cnt[b] <= CNT_W'(TRP - 1);
        else if (trp_cnt[b] != '0)
          trp_cnt[b] <= trp_cnt[b] - CNT_W'(1);
      end
    end
  end
`else
  assign timing = 1'b0;
`endif

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      prev_cke   <= 1'b1;
      pwr_q      <= PWR_ACTIVE;
      cmd_code   <= C_NOP;
      cmd_ba     <= '0;
      cmd_row    <= '0;
      cmd_col    <= '0;
      bank_open  <= '0;
      proto_err  <= 1'b0;
      timing_err <= 1'b0;
      err_count  <= '0;
    end else begin
      prev_cke   <= cke;
      pwr_q      <= pwr_d;
      cmd_code   <= code;
      cmd_ba     <= ba;
      cmd_row    <= addr;
      cmd_col    <= {addr[11], addr[9:0]};
      bank_open  <= bank_d;
      proto_err  <= proto;
      timing_err <= timing;
      if ((proto || timing) && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end
  end

  // Row table is data only; the open flag in bank_open says whether an entry is meaningful
  always_ff @(posedge ck) begin
    if (code == C_ACT) open_row_unused[ba] <= addr;
  end

endmodule

// File: tb/tb_ddr3_cmd_tracker.sv
// Bench for ddr3_cmd_tracker: directed scenarios plus randomized commands against a cycle-stamp reference model.
module tb_ddr3_cmd_tracker;
  localparam int BA_BITS = 3, ADDR_BITS = 16, TRCD = 11, TRP = 11, NB = 8;
  localparam int K_DES = 0, K_MRS = 1, K_REF = 2, K_PRE = 3, K_ACT = 4,
                 K_WR = 5, K_RD = 6, K_ZQ = 7, K_NOP = 8;

  logic ck = 1'b0, rst_n = 1'b1;
  logic cke, cs_n, ras_n, cas_n, we_n;
  logic [BA_BITS-1:0] ba;
  logic [ADDR_BITS-1:0] addr;
  logic [4:0] cmd_code;
  logic [BA_BITS-1:0] cmd_ba;
  logic [ADDR_BITS-1:0] cmd_row;
  logic [10:0] cmd_col;
  logic [NB-1:0] bank_open;
  logic [1:0] pwr_state;
  logic proto_err, timing_err;
  logic [15:0] err_count;

  ddr3_cmd_tracker #(.BA_BITS(BA_BITS), .ADDR_BITS(ADDR_BITS), .TRCD(TRCD), .TRP(TRP)) dut (
    .ck(ck), .rst_n(rst_n), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .ba(ba), .addr(addr), .cmd_code(cmd_code), .cmd_ba(cmd_ba), .cmd_row(cmd_row),
    .cmd_col(cmd_col), .bank_open(bank_open), .pwr_state(pwr_state), .proto_err(proto_err),
    .timing_err(timing_err), .err_count(err_count)
  );

  always #5 ck = ~ck;

  int checks = 0, errors = 0;
  bit m_prev;
  int m_pwr;
  bit [NB-1:0] m_open;
  longint m_last_act [NB];
  longint m_last_pre [NB];
  int m_err;
  longint m_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 1'b1;
    m_pwr  = 0;
    m_open = '0;
    m_err  = 0;
    for (int i = 0; i < NB; i++) begin
      m_last_act[i] = -1000000;
      m_last_pre[i] = -1000000;
    end
  endtask

  function automatic bit [2:0] enc(input int k);
    case (k)
      K_MRS: return 3'b000;
      K_REF: return 3'b001;
      K_PRE: return 3'b010;
      K_ACT: return 3'b011;
      K_WR:  return 3'b100;
      K_RD:  return 3'b101;
      K_ZQ:  return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  function automatic int exp_code(input bit p, input bit c, input int k, input bit a10, input int pwr);
    if (p && c) begin
      case (k)
        K_DES: return 1;
        K_MRS: return 2;
        K_REF: return 3;
        K_PRE: return a10 ? 7 : 6;
        K_ACT: return 8;
        K_WR:  return a10 ? 10 : 9;
        K_RD:  return a10 ? 12 : 11;
        K_ZQ:  return a10 ? 15 : 16;
        default: return 0;
      endcase
    end else if (p && !c) begin
      if (k == K_REF) return 4;
      if (k == K_NOP || k == K_DES) return 13;
      return 31;
    end else if (!p && c) begin
      if (k == K_NOP || k == K_DES) return (pwr == 2) ? 5 : 14;
      return 31;
    end
    return 0;
  endfunction

  task automatic check_all(input int code, input bit [2:0] b, input bit [15:0] a,
                           input bit pr, input bit tm);
    chk("cmd_code", 32'(cmd_code), 32'(code));
    chk("cmd_ba", 32'(cmd_ba), 32'(b));
    chk("cmd_row", 32'(cmd_row), 32'(a));
    chk("cmd_col", 32'(cmd_col), 32'({a[11], a[9:0]}));
    chk("bank_open", 32'(bank_open), 32'(m_open));
    chk("pwr_state", 32'(pwr_state), 32'(m_pwr));
    chk("proto_err", 32'(proto_err), 32'(pr));
    chk("timing_err", 32'(timing_err), 32'(tm));
    chk("err_count", 32'(err_count), 32'(m_err));
  endtask

  task automatic step(input bit c, input int k, input bit [2:0] b, input bit [15:0] a, input bit do_chk);
    int code;
    bit pr, tm;
    cke = c; cs_n = (k == K_DES); {ras_n, cas_n, we_n} = enc(k); ba = b; addr = a;
    code = exp_code(m_prev, c, k, a[10], m_pwr);
    pr = 1'b0;
    case (code)
      31: pr = 1'b1;
      8: pr = m_open[b];
      9, 10, 11, 12: pr = !m_open[b];
      2, 3, 4, 15, 16: pr = (m_open != '0);
      default: ;
    endcase
    if (m_pwr != 0 && !(code inside {0, 1, 5, 14})) pr = 1'b1;
    tm = 1'b0;
`ifdef DDR3_CMD_TRACKER_TIMING_CHECK_EN
    if ((code inside {9, 10, 11, 12}) && (m_cyc - m_last_act[b]) < TRCD) tm = 1'b1;
    if (code == 8 && (m_cyc - m_last_pre[b]) < TRP) tm = 1'b1;
`endif
    if ((pr || tm) && m_err < 65535) m_err++;
    case (code)
      8: begin m_open[b] = 1'b1; m_last_act[b] = m_cyc; end
      6, 10, 12: begin m_open[b] = 1'b0; m_last_pre[b] = m_cyc; end
      7: begin
        m_open = '0;
        for (int i = 0; i < NB; i++) m_last_pre[i] = m_cyc;
      end
      default: ;
    endcase
    if (m_pwr == 0) begin
      if (code == 4) m_pwr = 2;
      else if (code == 13) m_pwr = 1;
    end else if (code == 5 || code == 14) begin
      m_pwr = 0;
    end
    m_prev = c;
    @(posedge ck);
    #1;
    m_cyc++;
    if (do_chk) check_all(code, b, a, pr, tm);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(0, 3'd0, 16'd0, 1'b0, 1'b0);
    @(posedge ck);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [15:0] a;
    bit [2:0] b;
    int r, k, gap;
    cke = 1'b1; cs_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1; ba = '0; addr = '0;
    #1;
    do_reset();

    // ACT then RD after 12 cycles: clean
    step(1, K_ACT, 3'd2, 16'h1234, 1);
    chk("act_code", 32'(cmd_code), 32'd8);
    repeat (11) step(1, K_NOP, 3'd0, 16'h0000, 1);
    step(1, K_RD, 3'd2, 16'h0000, 1);
    chk("rd_code", 32'(cmd_code), 32'd11);
    chk("rd_bank_open", 32'(bank_open), 32'h04);
    chk("rd_no_err", 32'(err_count), 32'd0);

    // RD to closed bank 5
    step(1, K_RD, 3'd5, 16'h0021, 1);
    chk("closed_rd_proto", 32'(proto_err), 32'd1);
    chk("closed_rd_count", 32'(err_count), 32'd1);

    // ACT then RD 3 cycles later
    do_reset();
    step(1, K_ACT, 3'd0, 16'h0100, 1);
    step(1, K_NOP, 3'd0, 16'h0000, 1);
    step(1, K_NOP, 3'd0, 16'h0000, 1);
    step(1, K_RD, 3'd0, 16'h0000, 1);
    chk("trcd_proto", 32'(proto_err), 32'd0);
`ifdef DDR3_CMD_TRACKER_TIMING_CHECK_EN
    chk("trcd_timing", 32'(timing_err), 32'd1);
    chk("trcd_count", 32'(err_count), 32'd1);
`else
    chk("trcd_timing", 32'(timing_err), 32'd0);
    chk("trcd_count", 32'(err_count), 32'd0);
`endif

    // Self refresh then power down round trips
    do_reset();
    step(0, K_REF, 3'd0, 16'h0000, 1);
    chk("sre_pwr", 32'(pwr_state), 32'd2);
    repeat (5) step(0, K_NOP, 3'd0, 16'h0000, 1);
    step(1, K_NOP, 3'd0, 16'h0000, 1);
    chk("srx_code", 32'(cmd_code), 32'd5);
    chk("srx_pwr", 32'(pwr_state), 32'd0);
    step(0, K_NOP, 3'd0, 16'h0000, 1);
    chk("pde_code", 32'(cmd_code), 32'd13);
    chk("pde_pwr", 32'(pwr_state), 32'd1);
    repeat (5) step(0, K_NOP, 3'd0, 16'h0000, 1);
    step(1, K_DES, 3'd0, 16'h0000, 1);
    chk("pdx_code", 32'(cmd_code), 32'd14);
    chk("pdx_pwr", 32'(pwr_state), 32'd0);

    // Reset in the middle of an open-bank sequence
    step(1, K_ACT, 3'd4, 16'h0abc, 1);
    step(1, K_NOP, 3'd0, 16'h0000, 1);
    do_reset();
    step(1, K_RD, 3'd4, 16'h0000, 1);
    chk("post_reset_rd_proto", 32'(proto_err), 32'd1);

    // Randomized command stream against the model
    do_reset();
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      a = 16'($urandom);
      b = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) b = 3'($urandom_range(0, NB - 1));
      if (r < 22) k = K_ACT;
      else if (r < 40) k = K_RD;
      else if (r < 55) k = K_WR;
      else if (r < 74) k = K_PRE;
      else if (r < 77) k = K_MRS;
      else if (r < 80) k = K_REF;
      else if (r < 83) k = K_ZQ;
      else if (r < 90) k = K_DES;
      else k = K_NOP;
      if (k == K_PRE) a[10] = (r >= 70);
      step(1, k, b, a, 1);
      gap = $urandom_range(0, 12);
      for (int g = 0; g < gap; g++) step(1, K_NOP, 3'd0, 16'h0000, 1);
    end

    // Banks open during REF, PREA closes all, then error counter saturation
    do_reset();
    step(1, K_ACT, 3'd1, 16'h0011, 1);
    step(1, K_ACT, 3'd3, 16'h0033, 1);
    step(1, K_REF, 3'd0, 16'h0000, 1);
    chk("ref_open_proto", 32'(proto_err), 32'd1);
    step(1, K_PRE, 3'd0, 16'h0400, 1);
    chk("prea_bank_open", 32'(bank_open), 32'd0);
    for (int i = 0; i < 65536; i++) step((i % 2) == 1, K_ACT, 3'd0, 16'h0000, 0);
    chk("sat_count", 32'(err_count), 32'hFFFF);
    step(0, K_ACT, 3'd0, 16'h0000, 1);
    step(1, K_ACT, 3'd0, 16'h0000, 1);
    chk("sat_hold", 32'(err_count), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
